regfile_dual_wb: RTL and testbench

REGFILE_DUAL_WB -- requirements
Module: regfile_dual_wb

---
 rtl/regfile_dual_wb.sv | 83 ++++++++
 tb/tb_regfile_dual_wb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dual_wb.sv
// rtl/regfile_dual_wb.sv - dual write-back, quad read 32x32 register file (optional WB_BYPASS_EN)
module regfile_dual_wb (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteEn_inst1_WB,
  input  logic [4:0]  dest_reg_inst1_WB,
  input  logic [31:0] writeData_inst1_WB,
  input  logic        RegWriteEn_inst2_WB,
  input  logic [4:0]  dest_reg_inst2_WB,
  input  logic [31:0] writeData_inst2_WB,
  input  logic [4:0]  rs_addr_inst1,
  input  logic [4:0]  rt_addr_inst1,
  input  logic [4:0]  rs_addr_inst2,
  input  logic [4:0]  rt_addr_inst2,
  output logic [31:0] rs_data_inst1,
  output logic [31:0] rt_data_inst1,
  output logic [31:0] rs_data_inst2,
  output logic [31:0] rt_data_inst2,
  output logic        wb_collision
);

  logic [31:0] regs [32];
  logic [4:0]  raddr [4];
  logic [31:0] rdata [4];

  logic wr1_ok;
  logic wr2_ok;

  // A write to register 0 is dropped entirely, so it never counts as a real write.
  assign wr1_ok = RegWriteEn_inst1_WB && (dest_reg_inst1_WB != 5'd0);
  assign wr2_ok = RegWriteEn_inst2_WB && (dest_reg_inst2_WB != 5'd0);

  // Commit both write slots; slot 2 is issued second so it wins on a shared destination.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
      wb_collision <= 1'b0;
    end else begin
      if (wr1_ok) begin
        regs[dest_reg_inst1_WB] <= writeData_inst1_WB;
      end
      if (wr2_ok) begin
        regs[dest_reg_inst2_WB] <= writeData_inst2_WB;
      end
      wb_collision <= wr1_ok && wr2_ok && (dest_reg_inst1_WB == dest_reg_inst2_WB);
    end
  end

  assign raddr[0] = rs_addr_inst1;
  assign raddr[1] = rt_addr_inst1;
  assign raddr[2] = rs_addr_inst2;
  assign raddr[3] = rt_addr_inst2;

  // Four independent combinational read ports; address 0 is hard-wired to zero.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      rdata[p] = regs[raddr[p]];
`ifdef WB_BYPASS_EN
      // Forward same-cycle write data, youngest slot last so it takes priority.
      // Bypass is suppressed in reset so reads show the cleared state.
      if (reset && wr1_ok && (dest_reg_inst1_WB == raddr[p])) begin
        rdata[p] = writeData_inst1_WB;
      end
      if (reset && wr2_ok && (dest_reg_inst2_WB == raddr[p])) begin
        rdata[p] = writeData_inst2_WB;
      end
`else
      // Reads show committed state only; a write is visible from the next cycle.
`endif
      if (raddr[p] == 5'd0) begin
        rdata[p] = 32'h0;
      end
    end
  end

  assign rs_data_inst1 = rdata[0];
  assign rt_data_inst1 = rdata[1];
  assign rs_data_inst2 = rdata[2];
  assign rt_data_inst2 = rdata[3];

endmodule

// File: tb/tb_regfile_dual_wb.sv
// tb/tb_regfile_dual_wb.sv - self-checking bench for regfile_dual_wb
module tb_regfile_dual_wb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWriteEn_inst1_WB;
  logic [4:0]  dest_reg_inst1_WB;
  logic [31:0] writeData_inst1_WB;
  logic        RegWriteEn_inst2_WB;
  logic [4:0]  dest_reg_inst2_WB;
  logic [31:0] writeData_inst2_WB;
  logic [4:0]  rs_addr_inst1;
  logic [4:0]  rt_addr_inst1;
  logic [4:0]  rs_addr_inst2;
  logic [4:0]  rt_addr_inst2;
  logic [31:0] rs_data_inst1;
  logic [31:0] rt_data_inst1;
  logic [31:0] rs_data_inst2;
  logic [31:0] rt_data_inst2;
  logic        wb_collision;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  regfile_dual_wb dut (
    .clk                 (clk),
    .reset               (reset),
    .RegWriteEn_inst1_WB (RegWriteEn_inst1_WB),
    .dest_reg_inst1_WB   (dest_reg_inst1_WB),
    .writeData_inst1_WB  (writeData_inst1_WB),
    .RegWriteEn_inst2_WB (RegWriteEn_inst2_WB),
    .dest_reg_inst2_WB   (dest_reg_inst2_WB),
    .writeData_inst2_WB  (writeData_inst2_WB),
    .rs_addr_inst1       (rs_addr_inst1),
    .rt_addr_inst1       (rt_addr_inst1),
    .rs_addr_inst2       (rs_addr_inst2),
    .rt_addr_inst2       (rt_addr_inst2),
    .rs_data_inst1       (rs_data_inst1),
    .rt_data_inst1       (rt_data_inst1),
    .rs_data_inst2       (rs_data_inst2),
    .rt_data_inst2       (rt_data_inst2),
    .wb_collision        (wb_collision)
  );

  always #5 clk = ~clk;

  // Reference model: a plain array updated in program order (slot 1, then slot 2).
  logic [31:0] mem [32];
  bit          m_col;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      m_col = 1'b0;
    end else begin
      m_col = RegWriteEn_inst1_WB && RegWriteEn_inst2_WB &&
              dest_reg_inst1_WB == dest_reg_inst2_WB && dest_reg_inst1_WB != 0;
      if (RegWriteEn_inst1_WB) mem[dest_reg_inst1_WB] = writeData_inst1_WB;
      if (RegWriteEn_inst2_WB) mem[dest_reg_inst2_WB] = writeData_inst2_WB;
      mem[0] = 32'h0;
    end
  end

  function automatic logic [31:0] mref(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (reset && RegWriteEn_inst2_WB && dest_reg_inst2_WB == a) return writeData_inst2_WB;
    if (reset && RegWriteEn_inst1_WB && dest_reg_inst1_WB == a) return writeData_inst1_WB;
`endif
    return mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_rs1", rs_data_inst1, mref(rs_addr_inst1));
      chk("m_rt1", rt_data_inst1, mref(rt_addr_inst1));
      chk("m_rs2", rs_data_inst2, mref(rs_addr_inst2));
      chk("m_rt2", rt_data_inst2, mref(rt_addr_inst2));
      chk("m_col", {31'b0, wb_collision}, {31'b0, m_col});
    end
  end

  task automatic idle();
    RegWriteEn_inst1_WB = 0; dest_reg_inst1_WB = 0; writeData_inst1_WB = 32'hCAFE_F00D;
    RegWriteEn_inst2_WB = 0; dest_reg_inst2_WB = 0; writeData_inst2_WB = 32'hBAAD_F00D;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_all(input logic [4:0] a);
    rs_addr_inst1 = a; rt_addr_inst1 = a; rs_addr_inst2 = a; rt_addr_inst2 = a;
  endtask

  initial begin
    idle();
    rd_all(5'd0);
    step();
    step();
    check_en = 1'b1;
    chk("rst_col", {31'b0, wb_collision}, 32'h0);
    #4;
    reset = 1'b1;
    step();

    // All addresses read zero after reset.
    for (int a = 0; a < 32; a++) begin
      rd_all(a[4:0]);
      #1;
      chk("post_rst_rd", rs_data_inst2, 32'h0);
      step();
    end
    chk("post_rst_col", {31'b0, wb_collision}, 32'h0);

    // Two different registers in one cycle.
    RegWriteEn_inst1_WB = 1; dest_reg_inst1_WB = 5; writeData_inst1_WB = 32'hA5A5_0001;
    RegWriteEn_inst2_WB = 1; dest_reg_inst2_WB = 6; writeData_inst2_WB = 32'h0000_BEEF;
    step();
    idle();
    rs_addr_inst1 = 5; rt_addr_inst1 = 6; rs_addr_inst2 = 6; rt_addr_inst2 = 5;
    #1;
    chk("r5_rs1", rs_data_inst1, 32'hA5A5_0001);
    chk("r6_rt1", rt_data_inst1, 32'h0000_BEEF);
    chk("r6_rs2", rs_data_inst2, 32'h0000_BEEF);
    chk("r5_rt2", rt_data_inst2, 32'hA5A5_0001);
    chk("dual_nocol", {31'b0, wb_collision}, 32'h0);
    step();

    // Disabled slots must not disturb state even with live-looking data.
    dest_reg_inst1_WB = 5; writeData_inst1_WB = 32'hFFFF_0000;
    dest_reg_inst2_WB = 5; writeData_inst2_WB = 32'h0000_FFFF;
    step();
    idle();
    #1;
    chk("dis_r5", rs_data_inst1, 32'hA5A5_0001);
    step();

    // Same-destination collision: slot 2 wins, flag for exactly one cycle.
    RegWriteEn_inst1_WB = 1; dest_reg_inst1_WB = 9; writeData_inst1_WB = 32'h1111_1111;
    RegWriteEn_inst2_WB = 1; dest_reg_inst2_WB = 9; writeData_inst2_WB = 32'h2222_2222;
    rd_all(5'd9);
    step();
    idle();
    chk("col_r9", rs_data_inst1, 32'h2222_2222);
    chk("col_flag", {31'b0, wb_collision}, 32'h1);
    step();
    chk("col_drop", {31'b0, wb_collision}, 32'h0);

    // Writes to r0 are ignored and r0 always reads zero.
    RegWriteEn_inst2_WB = 1; dest_reg_inst2_WB = 0; writeData_inst2_WB = 32'hFFFF_FFFF;
    rd_all(5'd0);
    #1;
    chk("r0_same", rs_data_inst1, 32'h0);
    step();
    chk("r0_after", rs_data_inst1, 32'h0);
    chk("r0_nocol", {31'b0, wb_collision}, 32'h0);
    RegWriteEn_inst1_WB = 1; dest_reg_inst1_WB = 0; writeData_inst1_WB = 32'h5555_5555;
    step();
    idle();
    chk("r0_both_nocol", {31'b0, wb_collision}, 32'h0);
    chk("r0_both_rd", rt_data_inst2, 32'h0);

    // Read during write: bypass-dependent.
    RegWriteEn_inst1_WB = 1; dest_reg_inst1_WB = 7; writeData_inst1_WB = 32'h1234_5678;
    rd_all(5'd0);
    rt_addr_inst2 = 7;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_same", rt_data_inst2, 32'h1234_5678);
`else
    chk("byp_same", rt_data_inst2, 32'h0);
`endif
    step();
    idle();
    chk("byp_next", rt_data_inst2, 32'h1234_5678);
    step();

    // Mid-cycle reset clears state immediately and discards writes under reset.
    RegWriteEn_inst1_WB = 1; dest_reg_inst1_WB = 3; writeData_inst1_WB = 32'hDEAD_BEEF;
    step();
    idle();
    rd_all(5'd3);
    rt_addr_inst2 = 4;
    #1;
    chk("r3_set", rs_data_inst1, 32'hDEAD_BEEF);
    #1;
    reset = 1'b0;
    #1;
    chk("r3_async_clr", rs_data_inst1, 32'h0);
    chk("r5_async_clr", {27'b0, rs_addr_inst1}, 32'h3);
    RegWriteEn_inst2_WB = 1; dest_reg_inst2_WB = 4; writeData_inst2_WB = 32'h4444_4444;
    step();
    chk("rst_wr_col", {31'b0, wb_collision}, 32'h0);
    idle();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_wr_drop", rt_data_inst2, 32'h0);
    RegWriteEn_inst1_WB = 1; dest_reg_inst1_WB = 8; writeData_inst1_WB = 32'h8888_0008;
    rs_addr_inst2 = 8;
    step();
    idle();
    chk("first_wr_after_rst", rs_data_inst2, 32'h8888_0008);
    chk("r5_still_clr", rs_data_inst1, 32'h0);
    step();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
